// File: rtl/gray_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared types and constants for the grayscale sequencer:
//            FSM state encoding, default luma coefficients (IEEE-754
//            single precision) and channel index constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CVT  = 3'd2,
    S_MUL  = 3'd3,
    S_ACC  = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [31:0] c_CR_DEF = 32'h3E991687;  // 0.299
  localparam logic [31:0] c_CG_DEF = 32'h3F1645A2;  // 0.587
  localparam logic [31:0] c_CB_DEF = 32'h3DE978D5;  // 0.114

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

endpackage

`default_nettype wire

// File: rtl/gray_addr_cnt.sv
// ============================================================================
// Module   : gray_addr_cnt
// Purpose  : Pixel address counter with clear, increment and last flag.
//            Increment is ignored on the last address so it never wraps.
// Ports    : clk, rst (async, active high), i_clr, i_inc,
//            o_addr [ADDR_W-1:0], o_last (o_addr == NPIX-1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_addr_cnt #(
  parameter int ADDR_W = 10,
  parameter int NPIX   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NPIX - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              w_last;

  assign w_last = (r_addr == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_inc && !w_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_last;

endmodule

`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
// ============================================================================
// Module   : gray_seq_ctrl
// Purpose  : RGB-to-grayscale sequencer. Time-multiplexes one external
//            int_to_float, one mul_float and one adder across the R, G, B
//            channels, computing gray = CR*R + CG*G + CB*B per pixel and
//            presenting each result on a valid/ready port.
// Ports    : clk, rst (async, active high), start, abort, busy, done,
//            mem_addr, chan_sel, pix_in, itf_in/itf_out, mul_a/mul_b/mul_p,
//            add_a/add_b/add_s, out_valid, out_ready, out_data, out_addr,
//            stall_cnt (only with GRAY_STALL_CNT_EN)
// Options  : GRAY_STALL_CNT_EN - adds a saturating count of OUT cycles
//            with out_ready low, cleared on frame start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter int          NPIX   = 1024,
  parameter logic [31:0] CR     = c_CR_DEF,
  parameter logic [31:0] CG     = c_CG_DEF,
  parameter logic [31:0] CB     = c_CB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        chan_sel,
  input  logic [7:0]        pix_in,
  output logic [7:0]        itf_in,
  input  logic [31:0]       itf_out,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_p,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef GRAY_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_chan;
  logic [7:0]        r_pix;
  logic [31:0]       r_flt;
  logic [31:0]       r_prod;
  logic [31:0]       r_acc;
  logic [31:0]       r_out_data;
  logic [ADDR_W-1:0] r_out_addr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_frame_go;
  logic              w_handshake;
  logic              w_addr_inc;
  logic [31:0]       w_coef;
  logic [31:0]       w_acc_next;

  // Frame start and OUT handshakes are both suppressed by abort.
  assign w_frame_go  = (r_state == S_IDLE) && start && !abort;
  assign w_handshake = (r_state == S_OUT) && out_ready && !abort;
  assign w_addr_inc  = w_handshake && !w_last;

  gray_addr_cnt #(
    .ADDR_W (ADDR_W),
    .NPIX   (NPIX)
  ) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_frame_go),
    .i_inc  (w_addr_inc),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_comb begin
    case (r_chan)
      CH_R:    w_coef = CR;
      CH_G:    w_coef = CG;
      default: w_coef = CB;
    endcase
  end

  // Red channel seeds the accumulator directly, so the adder is bypassed.
  assign w_acc_next = (r_chan == CH_R) ? r_prod : add_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and shared-unit operand drive
  always_comb begin
    w_next = r_state;
    itf_in = 8'd0;
    mul_a  = 32'd0;
    mul_b  = 32'd0;
    add_a  = 32'd0;
    add_b  = 32'd0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RD;
      S_RD:   w_next = S_CVT;
      S_CVT: begin
        itf_in = r_pix;
        w_next = S_MUL;
      end
      S_MUL: begin
        mul_a  = w_coef;
        mul_b  = r_flt;
        w_next = S_ACC;
      end
      S_ACC: begin
        if (r_chan != CH_R) begin
          add_a = r_prod;
          add_b = r_acc;
        end
        w_next = (r_chan == CH_B) ? S_OUT : S_RD;
      end
      S_OUT:  if (out_ready) w_next = w_last ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Datapath registers; an abort cycle leaves all of them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chan     <= CH_R;
      r_pix      <= 8'd0;
      r_flt      <= 32'd0;
      r_prod     <= 32'd0;
      r_acc      <= 32'd0;
      r_out_data <= 32'd0;
      r_out_addr <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: if (start) r_chan <= CH_R;
        S_RD:   r_pix  <= pix_in;
        S_CVT:  r_flt  <= itf_out;
        S_MUL:  r_prod <= mul_p;
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_chan == CH_B) begin
            r_out_data <= w_acc_next;
            r_out_addr <= w_addr;
          end else begin
            r_chan <= r_chan + 2'd1;
          end
        end
        S_OUT:  if (out_ready && !w_last) r_chan <= CH_R;
        default: ;
      endcase
    end
  end

`ifdef GRAY_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_frame_go) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == S_OUT) && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_OUT);
  assign mem_addr  = w_addr;
  assign chan_sel  = r_chan;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

endmodule

`default_nettype wire

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Sequencer for the RGB-to-grayscale datapath. Time-multiplexes one int_to_float, one mul_float and one cong_32bit across the R, G and B channels, instead of instantiating three of each.
- Walks pixel addresses 0..NPIX-1. For each pixel it computes gray = CR*R + CG*G + CB*B in IEEE-754 single precision.
- Presents each result on a valid/ready output port. Sits between the IMEMR/G/B memories and the result consumer.

Parameters:
- ADDR_W, 10, pixel address width.
- NPIX, 1024, pixels per frame; legal range 1..2^ADDR_W.
- CR, 32'h3E991687, red coefficient (0.299).
- CG, 32'h3F1645A2, green coefficient (0.587).
- CB, 32'h3DE978D5, blue coefficient (0.114).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin frame; sampled in IDLE only.
- abort  in  1  cancel frame; return to IDLE next cycle, no done pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pixel's handshake.
- mem_addr  out  ADDR_W  pixel address to IMEMR/G/B.
- chan_sel  out  2  0=R, 1=G, 2=B; drives the memory read mux.
- pix_in  in  8  selected channel byte; combinational memory read.
- itf_in  out  8  to shared int_to_float.
- itf_out  in  32  from int_to_float.
- mul_a, mul_b  out  32  to shared mul_float (coefficient, sample).
- mul_p  in  32  product.
- add_a, add_b  out  32  to shared cong_32bit.
- add_s  in  32  sum.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  32  float gray value.
- out_addr  out  ADDR_W  address of the pixel in out_data.

Behaviour:
- Reset: state=IDLE; addr, chan, pix_q, flt_q, prod_q, acc_q all 0; busy=0, done=0, out_valid=0, out_data=0, out_addr=0; mem_addr=0, chan_sel=0.
- All shared units are combinational. Each step takes one cycle and registers the unit's output at the end of that cycle.
- States: IDLE, RD, CVT, MUL, ACC, OUT, DONE.
- IDLE -> RD when start=1; addr<=0, chan<=0.
- RD: mem_addr=addr, chan_sel=chan; pix_q<=pix_in.
- CVT: itf_in=pix_q; flt_q<=itf_out.
- MUL: mul_a=coef[chan], mul_b=flt_q; prod_q<=mul_p.
- ACC:
  - chan=0: acc_q<=prod_q (adder bypassed).
  - chan>0: add_a=prod_q, add_b=acc_q; acc_q<=add_s.
  - chan<2: chan++, go to RD.
  - chan=2: out_data<=final sum, out_addr<=addr, go to OUT.
- OUT:
  - out_valid=1. out_data and out_addr are held stable until out_ready=1.
  - On handshake, if addr==NPIX-1, go to DONE; otherwise addr++, chan<=0, go to RD.
- DONE: done=1 for one cycle, then IDLE.
- Timing:
  - 12 cycles per pixel before out_valid.
  - start sampled at edge 0 gives out_valid high in cycle 13.
  - Zero-stall frame time is 13*NPIX+1 cycles after start.
- Unused datapath outputs (itf_in, mul_*, add_*) are driven 0 outside their states.
- Boundaries:
  - start while busy is ignored.
  - abort has priority over every transition, including an OUT handshake in the same cycle. Abort forces IDLE with out_valid=0 and no done pulse; registers keep their values except state.
  - start and abort together in IDLE: stay in IDLE.
  - NPIX=1: one pixel, then DONE.
  - addr never wraps.
  - Async rst mid-frame returns everything to reset values immediately.

Optional Feature:
- Macro GRAY_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles in OUT with out_ready=0, saturating at 16'hFFFF.
  - Cleared on rst and on frame start (IDLE->RD).
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gray_pkg holds:
  - the state enum and its width;
  - default coefficient constants CR/CG/CB;
  - the channel index constants CH_R/CH_G/CH_B.
- One sub-module, gray_addr_cnt:
  - pixel address counter with clear, increment and last-flag (addr==NPIX-1);
  - async active-high reset.

Test Plan:
- rst mid-frame (during MUL of pixel 3) -> all outputs at reset values that cycle; a new start restarts from addr 0.
- NPIX=4, all memories 0, out_ready=1 -> four outputs of 32'h00000000, out_addr 0..3, done at cycle 53, busy low at cycle 54.
- R=100, G=0, B=0 at addr 0 -> out_data 32'h41EF3333 (29.9) within ±1 ulp; out_valid first high in cycle 13.
- R=G=B=255 -> out_data 32'h437F0000 (255.0) within ±2 ulp against the bench float model.
- out_ready held low 20 cycles in OUT -> out_data and out_addr stable, no addr advance; with GRAY_STALL_CNT_EN, stall_cnt=20.
- abort asserted in ACC of pixel 2 -> IDLE next cycle, busy=0, done never pulses; start ignored while busy, accepted after.
